// File: rtl/tree_loader.sv
// tree_loader: writer side of the treeval node-load interface.
// Takes packed node records from a valid/ready stream, programs the node count,
// then serializes each record into per-field memory strobes. After the final
// node it pulses eval_rst so treeval restarts on the new tree.
//
// state | meaning
// IDLE  | waiting for an acceptable start
// CONF  | node count presented on conf_data
// WAIT  | s_ready high, waiting for the next record
// PAR   | parent field written
// ACT   | {strat,action} written
// REW   | reward written
// WGT   | weight written, framing checked
// RST   | eval_rst pulse to treeval
// DONE  | done pulse
// ABORT | framing error, err raised
module tree_loader #(
  parameter int W_ADDR   = 10,
  parameter int W_DATA   = 10,
  parameter int W_CONF   = 10,
  parameter int W_ACTION = 3,
  parameter int W_REWARD = 10,
  parameter int W_WEIGHT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [W_ADDR-1:0] node_count,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_node,
  input  logic              s_last,
  output logic              mem_par,
  output logic              mem_act,
  output logic              mem_rew,
  output logic              mem_weight,
  output logic [W_ADDR-1:0] mem_addr,
  output logic [W_DATA-1:0] mem_data,
  output logic              conf_nodes,
  output logic [W_CONF-1:0] conf_data,
  output logic              eval_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    S_IDLE, S_CONF, S_WAIT, S_PAR, S_ACT, S_REW, S_WGT, S_RST, S_DONE, S_ABORT
  } state_t;

  state_t            state, nxt;
  logic [W_ADDR-1:0] cnt_q, addr_q, addr_nxt, cnt_cur;
  logic [31:0]       rec_q, rec_cur;
  logic              last_q;
  logic              accept_start, start_bad, accept_rec, is_last_addr, is_root;
  logic [W_DATA-1:0] data_nxt;

  // Next-state decode, start/record acceptance and framing check.
  always_comb begin
    nxt          = state;
    accept_start = 1'b0;
    start_bad    = 1'b0;
    accept_rec   = 1'b0;
    is_last_addr = (addr_q == cnt_q - W_ADDR'(1));
    case (state)
      S_IDLE: begin
        if (start) begin
          if (node_count >= W_ADDR'(2)) begin
            accept_start = 1'b1;
            nxt          = S_CONF;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      S_CONF:  nxt = S_WAIT;
      S_WAIT: begin
        if (s_valid && s_ready) begin
          accept_rec = 1'b1;
          nxt        = S_PAR;
        end
      end
      S_PAR:   nxt = S_ACT;
      S_ACT:   nxt = S_REW;
      S_REW:   nxt = S_WGT;
      S_WGT: begin
        // s_last must coincide exactly with the final address
        if (last_q != is_last_addr) nxt = S_ABORT;
        else if (is_last_addr)      nxt = S_RST;
        else                        nxt = S_WAIT;
      end
      S_RST:   nxt = S_DONE;
      S_DONE:  nxt = S_IDLE;
      S_ABORT: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // Datapath selects: the PAR cycle is registered on the accept edge, so the
  // live s_node is used there instead of the not-yet-latched copy.
  always_comb begin
    rec_cur  = (state == S_WAIT) ? s_node : rec_q;
    cnt_cur  = accept_start ? node_count : cnt_q;
    is_root  = (addr_q == '0);
    addr_nxt = addr_q;
    if (accept_start)                          addr_nxt = '0;
    else if (state == S_WGT && nxt == S_WAIT)  addr_nxt = addr_q + W_ADDR'(1);
    data_nxt = '0;
    case (nxt)
      S_PAR:   data_nxt = is_root ? '1 : W_DATA'(rec_cur[31:22]);
      S_ACT:   data_nxt = W_DATA'({rec_cur[18], rec_cur[21:19]});
      S_REW:   data_nxt = W_DATA'(rec_cur[17:8]);
      S_WGT:   data_nxt = is_root ? '0 : W_DATA'(rec_cur[7:0]);
      default: data_nxt = '0;
    endcase
  end

  // State, count, address counter and record latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt_q  <= '0;
      addr_q <= '0;
      rec_q  <= '0;
      last_q <= 1'b0;
    end else begin
      state  <= nxt;
      cnt_q  <= cnt_cur;
      addr_q <= addr_nxt;
      if (accept_rec) begin
        rec_q  <= s_node;
        last_q <= s_last;
      end
    end
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready    <= 1'b0;
      mem_par    <= 1'b0;
      mem_act    <= 1'b0;
      mem_rew    <= 1'b0;
      mem_weight <= 1'b0;
      mem_addr   <= '0;
      mem_data   <= '0;
      conf_nodes <= 1'b0;
      conf_data  <= '0;
      eval_rst   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      s_ready    <= (nxt == S_WAIT);
      mem_par    <= (nxt == S_PAR);
      mem_act    <= (nxt == S_ACT);
      mem_rew    <= (nxt == S_REW);
      mem_weight <= (nxt == S_WGT);
      mem_addr   <= (nxt inside {S_PAR, S_ACT, S_REW, S_WGT}) ? addr_nxt : '0;
      mem_data   <= data_nxt;
      conf_nodes <= (nxt == S_CONF);
      conf_data  <= (nxt == S_CONF) ? W_CONF'(cnt_cur) : '0;
      eval_rst   <= (nxt == S_RST);
      busy       <= (nxt != S_IDLE);
      done       <= (nxt == S_DONE);
      if (accept_start)                      err <= 1'b0;
      else if (start_bad || nxt == S_ABORT)  err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tree_loader.sv
// Directed bench for tree_loader: full loads, backpressure, framing abort,
// bad start count, start during a load, and reset in the middle of a load.
module tb_tree_loader;

  logic        clk, rst_n, start, s_valid, s_ready, s_last;
  logic [9:0]  node_count, mem_addr, mem_data, conf_data;
  logic [31:0] s_node;
  logic        mem_par, mem_act, mem_rew, mem_weight, conf_nodes, eval_rst, busy, done, err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int conf_cnt = 0, done_cnt = 0, rst_cnt = 0, strobe_cnt = 0;
  int conf_cyc = 0, done_cyc = 0;
  logic [9:0] conf_val;
  logic [9:0] par_m [0:7];
  logic [9:0] act_m [0:7];
  logic [9:0] rew_m [0:7];
  logic [9:0] wgt_m [0:7];

  tree_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .node_count(node_count),
    .s_valid(s_valid), .s_ready(s_ready), .s_node(s_node), .s_last(s_last),
    .mem_par(mem_par), .mem_act(mem_act), .mem_rew(mem_rew), .mem_weight(mem_weight),
    .mem_addr(mem_addr), .mem_data(mem_data), .conf_nodes(conf_nodes),
    .conf_data(conf_data), .eval_rst(eval_rst), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int p, input int a, input int s, input int r, input int w);
    return {p[9:0], a[2:0], s[0], r[9:0], w[7:0]};
  endfunction

  // monitor: bus invariants every cycle, plus a record of what was written
  always @(negedge clk) begin
    if (rst_n) begin
      logic any;
      any = mem_par | mem_act | mem_rew | mem_weight;
      chk("onehot", 32'($countones({mem_par, mem_act, mem_rew, mem_weight, conf_nodes}) <= 1), 32'd1);
      chk("idle_bus", 32'({any ? 10'd0 : mem_addr, any ? 10'd0 : mem_data,
                           conf_nodes ? 10'd0 : conf_data}), 32'd0);
      if (any) strobe_cnt++;
      if (mem_addr < 10'd8) begin
        if (mem_par)    par_m[mem_addr[2:0]] = mem_data;
        if (mem_act)    act_m[mem_addr[2:0]] = mem_data;
        if (mem_rew)    rew_m[mem_addr[2:0]] = mem_data;
        if (mem_weight) wgt_m[mem_addr[2:0]] = mem_data;
      end
      if (conf_nodes) begin conf_cnt++; conf_cyc = cyc; conf_val = conf_data; end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (eval_rst) rst_cnt++;
    end
  end

  task automatic do_start(input logic [9:0] n);
    @(negedge clk);
    start = 1'b1;
    node_count = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  // present one record after waiting gap cycles in WAIT; returns on a negedge
  task automatic send(input logic [31:0] rec, input logic last, input int gap);
    int k = 0;
    int sc;
    s_node = rec;
    s_last = last;
    s_valid = 1'b0;
    while (!s_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      chk("ready_timeout", 32'(s_ready), 32'd1);
      return;
    end
    sc = strobe_cnt;
    repeat (gap) begin
      @(negedge clk);
      chk("bp_ready", 32'(s_ready), 32'd1);
    end
    if (gap > 0) chk("bp_no_strobe", 32'(strobe_cnt - sc), 32'd0);
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int k = 0;
    while (done_cnt == d0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) chk("done_timeout", 32'(done_cnt - d0), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    int d0, r0, c0;
    rst_n = 1'b0; start = 1'b0; node_count = '0; s_valid = 1'b0; s_node = '0; s_last = 1'b0;
    #12;
    chk("reset_outputs", 32'({s_ready, mem_par, mem_act, mem_rew, mem_weight, conf_nodes,
                              eval_rst, busy, done, err}), 32'd0);
    chk("reset_bus", 32'({mem_addr, mem_data, conf_data}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // basic 3-node load
    d0 = done_cnt; r0 = rst_cnt;
    do_start(10'd3);
    send(mk(5, 2, 1, 40, 77), 1'b0, 0);
    send(mk(0, 1, 0, -8, 64), 1'b0, 0);
    send(mk(0, 1, 0, 20, 64), 1'b1, 0);
    wait_done(d0);
    chk("t1_conf", 32'(conf_val), 32'd3);
    chk("t1_par0", 32'(par_m[0]), 32'h3FF);
    chk("t1_act0", 32'(act_m[0]), 32'h0A);
    chk("t1_rew0", 32'(rew_m[0]), 32'd40);
    chk("t1_wgt0", 32'(wgt_m[0]), 32'd0);
    chk("t1_par1", 32'(par_m[1]), 32'd0);
    chk("t1_act1", 32'(act_m[1]), 32'h01);
    chk("t1_rew1", 32'(rew_m[1]), 32'h3F8);
    chk("t1_wgt1", 32'(wgt_m[1]), 32'd64);
    chk("t1_rew2", 32'(rew_m[2]), 32'd20);
    chk("t1_latency", 32'(done_cyc - conf_cyc), 32'd17);
    chk("t1_evalrst", 32'(rst_cnt - r0), 32'd1);
    chk("t1_idle", 32'({busy, err, s_ready}), 32'd0);

    // backpressure: 7 idle cycles before addr1
    d0 = done_cnt;
    do_start(10'd3);
    send(mk(5, 2, 1, 40, 77), 1'b0, 0);
    send(mk(0, 1, 0, -8, 64), 1'b0, 7);
    send(mk(0, 1, 0, 20, 64), 1'b1, 0);
    wait_done(d0);
    chk("t2_latency", 32'(done_cyc - conf_cyc), 32'd24);

    // early s_last on addr1 of a 4-node tree
    d0 = done_cnt; r0 = rst_cnt;
    do_start(10'd4);
    send(mk(3, 1, 0, 10, 5), 1'b0, 0);
    send(mk(0, 2, 1, 11, 9), 1'b1, 0);
    repeat (6) @(negedge clk);
    chk("t3_err", 32'(err), 32'd1);
    chk("t3_no_done", 32'(done_cnt - d0), 32'd0);
    chk("t3_no_evalrst", 32'(rst_cnt - r0), 32'd0);
    chk("t3_ready_busy", 32'({s_ready, busy}), 32'd0);
    chk("t3_wgt1", 32'(wgt_m[1]), 32'd9);

    // start with count below 2, then a good 2-node load
    do_start(10'd1);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("t4_busy_hold", 32'(busy), 32'd0);
    d0 = done_cnt;
    do_start(10'd2);
    chk("t4_err_clr", 32'(err), 32'd0);
    chk("t4_busy_on", 32'(busy), 32'd1);
    send(mk(0, 0, 0, 1, 2), 1'b0, 0);
    send(mk(0, 3, 0, 4, 128), 1'b1, 0);
    wait_done(d0);
    chk("t4_done", 32'(done_cnt - d0), 32'd1);
    chk("t4_wgt1", 32'(wgt_m[1]), 32'd128);

    // start pulsed mid-load is ignored
    d0 = done_cnt; c0 = conf_cnt;
    do_start(10'd2);
    send(mk(0, 0, 0, 1, 2), 1'b0, 0);
    start = 1'b1; node_count = 10'd5;
    @(negedge clk);
    start = 1'b0;
    send(mk(0, 5, 1, 7, 3), 1'b1, 0);
    wait_done(d0);
    chk("t5_conf_once", 32'(conf_cnt - c0), 32'd1);
    chk("t5_conf_val", 32'(conf_val), 32'd2);
    chk("t5_done", 32'(done_cnt - d0), 32'd1);
    chk("t5_act1", 32'(act_m[1]), 32'h0D);

    // reset asserted during REW of addr1
    do_start(10'd3);
    send(mk(0, 0, 0, 1, 2), 1'b0, 0);
    send(mk(0, 1, 0, 9, 8), 1'b0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("t6_in_rew", 32'({mem_rew, mem_addr}), 32'({1'b1, 10'd1}));
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_zero", 32'({s_ready, mem_par, mem_act, mem_rew, mem_weight, conf_nodes,
                              eval_rst, busy, done, err}), 32'd0);
    chk("t6_async_bus", 32'({mem_addr, mem_data, conf_data}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_idle", 32'({busy, s_ready}), 32'd0);
    d0 = done_cnt;
    do_start(10'd2);
    send(mk(0, 0, 0, 1, 2), 1'b0, 0);
    send(mk(0, 1, 0, 3, 4), 1'b1, 0);
    wait_done(d0);
    chk("t6_reload_done", 32'(done_cnt - d0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
